// File: rtl/audio_recorder.sv
// Record engine: captures codec samples and writes them as consecutive words
// into the selected SDRAM chunk over an Avalon-MM style write port.
module audio_recorder #(
    parameter int          ADDR_W    = 23,
    parameter int          DATA_W    = 16,
    parameter int unsigned MAX_WORDS = 32'h100000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              record_start,
    input  logic [ADDR_W-1:0] record_select,
    input  logic              record_pause,
    input  logic              record_stop,
    output logic              record_done,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic [ADDR_W-1:0] record_length,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE, WAIT_SAMPLE, WRITE, PAUSED, DONE, RELEASE
    } state_t;

    // One extra bit so a capacity equal to the full address space still compares.
    localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              stop_q, stop_d;
    logic              ovr_q, ovr_d;
    logic [ADDR_W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            stop_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stop_q  <= stop_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stop_d  = stop_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (record_start) begin
                    base_d  = record_select;
                    count_d = '0;
                    ovr_d   = 1'b0;
                    state_d = WAIT_SAMPLE;
                end
            end
            WAIT_SAMPLE: begin
                if (record_stop) begin
                    state_d = DONE;
                end else if (record_pause) begin
                    state_d = PAUSED;
                end else if (adc_valid) begin
                    wdata_d = adc_data;
                    addr_d  = base_q + count_q;
                    state_d = WRITE;
                end else if (!record_start) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // A write in flight always completes; stop is remembered until then.
                if (adc_valid)   ovr_d  = 1'b1;
                if (record_stop) stop_d = 1'b1;
                if (!mem_waitrequest) begin
                    count_d = count_inc[ADDR_W-1:0];
                    stop_d  = 1'b0;
                    if (count_inc == MAX_W || stop_q || record_stop)
                        state_d = DONE;
                    else
                        state_d = WAIT_SAMPLE;
                end
            end
            PAUSED: begin
                if (record_stop)        state_d = DONE;
                else if (!record_pause) state_d = WAIT_SAMPLE;
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!record_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_write     = (state_q == WRITE);
    assign record_done   = (state_q == DONE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign record_length = count_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a recording-level model.
module tb_audio_recorder;

    localparam int AW   = 23;
    localparam int DW   = 16;
    localparam int MAXW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          record_start = 1'b0;
    logic [AW-1:0] record_select = '0;
    logic          record_pause = 1'b0;
    logic          record_stop = 1'b0;
    logic          record_done;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_waitrequest = 1'b0;
    logic [AW-1:0] record_length;
    logic          overrun;

    audio_recorder #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .record_start(record_start), .record_select(record_select),
        .record_pause(record_pause), .record_stop(record_stop),
        .record_done(record_done),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest),
        .record_length(record_length), .overrun(overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Recording-level model: what the memory and control side must observe.
    bit          m_active, m_paused, m_fly, m_stopreq, m_done, m_hold, m_ovr;
    logic [AW-1:0] m_base, m_cnt, m_addr;
    logic [DW-1:0] m_wdata;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_active = 0; m_paused = 0; m_fly = 0; m_stopreq = 0;
            m_done = 0; m_hold = 0; m_ovr = 0;
            m_base = '0; m_cnt = '0; m_addr = '0; m_wdata = '0;
        end else if (m_done) begin
            m_done = 0;
            m_hold = 1;
        end else if (m_hold) begin
            if (!record_start) m_hold = 0;
        end else if (m_fly) begin
            if (adc_valid)   m_ovr = 1;
            if (record_stop) m_stopreq = 1;
            if (!mem_waitrequest) begin
                m_fly = 0;
                m_cnt = m_cnt + 1'b1;
                if (int'(m_cnt) == MAXW || m_stopreq) begin
                    m_done = 1;
                    m_active = 0;
                end
                m_stopreq = 0;
            end
        end else if (m_active) begin
            if (record_stop) begin
                m_active = 0; m_paused = 0; m_done = 1;
            end else if (m_paused) begin
                if (!record_pause) m_paused = 0;
            end else if (record_pause) begin
                m_paused = 1;
            end else if (adc_valid) begin
                m_fly = 1;
                m_addr = m_base + m_cnt;
                m_wdata = adc_data;
            end else if (!record_start) begin
                m_active = 0;
            end
        end else if (record_start) begin
            m_active = 1; m_base = record_select; m_cnt = '0; m_ovr = 0;
        end
    end

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            done_cnt = 0;

    always @(negedge i_clk) begin
        chk("mem_write", 32'(mem_write), 32'(m_fly));
        chk("record_done", 32'(record_done), 32'(m_done));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("record_length", 32'(record_length), 32'(m_cnt));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (mem_write && !mem_waitrequest) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (record_done) done_cnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic sample(input logic [DW-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic begin_rec(input logic [AW-1:0] base);
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        record_select = base;
        record_start = 1'b1;
        tick();
    endtask

    task automatic end_rec();
        record_stop = 1'b1;
        tick();
        record_stop = 1'b0;
        repeat (2) tick();
        record_start = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        repeat (3) tick();
        chk("reset mem_write", 32'(mem_write), 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset record_length", 32'(record_length), 0);
        chk("reset overrun", 32'(overrun), 0);
        i_rst_n = 1'b1;
        tick();

        // Three spaced samples, no stall.
        begin_rec(23'h200000);
        repeat (2) tick();
        sample(16'h1111); repeat (9) tick();
        sample(16'h2222); repeat (9) tick();
        sample(16'h3333); repeat (9) tick();
        end_rec();
        chk("t1 writes", 32'(log_addr.size()), 3);
        if (log_addr.size() == 3) begin
            chk("t1 addr0", 32'(log_addr[0]), 32'h200000);
            chk("t1 addr1", 32'(log_addr[1]), 32'h200001);
            chk("t1 addr2", 32'(log_addr[2]), 32'h200002);
            chk("t1 data0", 32'(log_data[0]), 32'h1111);
            chk("t1 data2", 32'(log_data[2]), 32'h3333);
        end
        chk("t1 done pulses", 32'(done_cnt), 1);
        chk("t1 length", 32'(record_length), 3);
        chk("t1 overrun", 32'(overrun), 0);

        // Second write stalled for five cycles.
        begin_rec(23'h000100);
        sample(16'hAAAA); repeat (3) tick();
        mem_waitrequest = 1'b1;
        sample(16'hBBBB);
        repeat (5) begin
            chk("t2 stall addr", 32'(mem_addr), 32'h101);
            chk("t2 stall data", 32'(mem_wdata), 32'hBBBB);
            tick();
        end
        mem_waitrequest = 1'b0;
        repeat (2) tick();
        chk("t2 writes", 32'(log_addr.size()), 2);
        chk("t2 length", 32'(record_length), 2);
        end_rec();

        // Pause with ignored samples, then continue without an address gap.
        begin_rec(23'h000300);
        sample(16'h0011); repeat (2) tick();
        sample(16'h0022); repeat (2) tick();
        record_pause = 1'b1; tick();
        repeat (4) begin sample(16'hDEAD); tick(); end
        record_pause = 1'b0; tick();
        sample(16'h0033); repeat (2) tick();
        chk("t3 writes", 32'(log_addr.size()), 3);
        if (log_addr.size() == 3)
            chk("t3 addr2", 32'(log_addr[2]), 32'h302);
        chk("t3 length", 32'(record_length), 3);
        chk("t3 overrun", 32'(overrun), 0);
        end_rec();

        // Capacity reached: auto-end, then hold in release while start is high.
        begin_rec(23'h000400);
        for (int i = 0; i < 6; i++) begin
            sample(16'(16'h4000 + i));
            repeat (2) tick();
        end
        chk("t4 writes", 32'(log_addr.size()), 4);
        chk("t4 done pulses", 32'(done_cnt), 1);
        chk("t4 length", 32'(record_length), 4);
        repeat (5) tick();
        chk("t4 no late writes", 32'(log_addr.size()), 4);
        record_start = 1'b0;
        repeat (2) tick();

        // Sample and stop both arrive during a stalled write.
        begin_rec(23'h000500);
        mem_waitrequest = 1'b1;
        sample(16'h0055);
        adc_valid = 1'b1; adc_data = 16'h0066; record_stop = 1'b1;
        tick();
        adc_valid = 1'b0; record_stop = 1'b0;
        tick();
        mem_waitrequest = 1'b0;
        repeat (2) tick();
        chk("t5 writes", 32'(log_addr.size()), 1);
        chk("t5 done pulses", 32'(done_cnt), 1);
        chk("t5 overrun", 32'(overrun), 1);
        record_start = 1'b0;
        repeat (2) tick();
        chk("t5 overrun sticky", 32'(overrun), 1);
        begin_rec(23'h000600);
        chk("t5 overrun cleared", 32'(overrun), 0);
        end_rec();

        // Address wrap at the top of the space, then reset during a write.
        begin_rec(23'h7FFFFE);
        for (int i = 0; i < 3; i++) begin
            sample(16'(16'h7000 + i));
            repeat (2) tick();
        end
        chk("t6 writes", 32'(log_addr.size()), 3);
        if (log_addr.size() == 3) begin
            chk("t6 addr0", 32'(log_addr[0]), 32'h7FFFFE);
            chk("t6 addr1", 32'(log_addr[1]), 32'h7FFFFF);
            chk("t6 addr2", 32'(log_addr[2]), 32'h000000);
        end
        mem_waitrequest = 1'b1;
        sample(16'h0077);
        chk("t6 in write", 32'(mem_write), 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("t6 rst mem_write", 32'(mem_write), 0);
        chk("t6 rst mem_addr", 32'(mem_addr), 0);
        chk("t6 rst mem_wdata", 32'(mem_wdata), 0);
        chk("t6 rst length", 32'(record_length), 0);
        chk("t6 rst done", 32'(record_done), 0);
        record_start = 1'b0;
        mem_waitrequest = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) record_start = ~record_start;
            if ($urandom_range(0, 15) == 0) record_pause = ~record_pause;
            record_select   = AW'($urandom);
            record_stop     = ($urandom_range(0, 39) == 0);
            adc_valid       = ($urandom_range(0, 2) == 0);
            adc_data        = DW'($urandom);
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            tick();
        end
        record_start = 1'b0; record_pause = 1'b0; record_stop = 1'b0;
        adc_valid = 1'b0; mem_waitrequest = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
